// File: rtl/store_drain_unit.sv
// store_drain_unit: drains released store-queue entries into registered memory write requests,
// bounding outstanding writes and serialising store-conditionals.
module store_drain_unit #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int SUBUNIT_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sq_valid,
   input  logic [31:0]          sq_addr,
   input  logic [3:0]           sq_be,
   input  logic [31:0]          sq_data,
   input  logic [SUBUNIT_W-1:0] sq_subunit_id,
   input  logic                 sq_is_amo_sc,
   output logic                 sq_pop,
   input  logic                 fence_req,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic [31:0]          mem_req_addr,
   output logic [3:0]           mem_req_be,
   output logic [31:0]          mem_req_data,
   output logic [SUBUNIT_W-1:0] mem_req_subunit,
   output logic                 mem_req_sc,
   input  logic                 mem_ack,
   input  logic                 mem_sc_rsp_valid,
   input  logic                 mem_sc_rsp_fail,
   output logic                 sc_result_valid,
   output logic [31:0]          sc_result,
   output logic                 drain_empty,
   output logic                 protocol_error
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   typedef enum logic {IDLE, SC_WAIT} state_t;
   typedef logic [CW:0] sum_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic req_valid_q, req_valid_d, req_sc_q, req_sc_d;
   logic [31:0] req_addr_q, req_addr_d, req_data_q, req_data_d;
   logic [3:0] req_be_q, req_be_d;
   logic [SUBUNIT_W-1:0] req_sub_q, req_sub_d;
   logic sc_valid_q, sc_valid_d, sc_fail_q, sc_fail_d, perr_q, perr_d;
   logic room, pop, load, accept, inc, dec;
   always_comb begin
      // a buffered non-SC request counts against the limit before it is accepted
      room = ((sum_t'(cnt_q) + sum_t'(req_valid_q & ~req_sc_q)) < sum_t'(MAX_OUTSTANDING))
             | sq_is_amo_sc | (sq_be == 4'b0);
      pop = ~rst & sq_valid & ~fence_req & (state_q == IDLE) & (~req_valid_q | mem_req_ready) & room;
      load = pop & (sq_is_amo_sc | (|sq_be));
      accept = req_valid_q & mem_req_ready;
      inc = accept & ~req_sc_q;
      dec = mem_ack & (cnt_q != '0);
      cnt_d = cnt_q + CW'(inc) - CW'(dec);
      req_valid_d = load | (req_valid_q & ~mem_req_ready);
      req_addr_d = load ? sq_addr : req_addr_q;
      req_be_d = load ? sq_be : req_be_q;
      req_data_d = load ? sq_data : req_data_q;
      req_sub_d = load ? sq_subunit_id : req_sub_q;
      req_sc_d = load ? sq_is_amo_sc : req_sc_q;
      state_d = (pop & sq_is_amo_sc) ? SC_WAIT :
                ((state_q == SC_WAIT) & mem_sc_rsp_valid) ? IDLE : state_q;
      sc_valid_d = (state_q == SC_WAIT) & mem_sc_rsp_valid;
      sc_fail_d = sc_valid_d ? mem_sc_rsp_fail : sc_fail_q;
      perr_d = perr_q | (mem_ack & (cnt_q == '0)) | (mem_sc_rsp_valid & (state_q == IDLE));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         req_valid_q <= 1'b0;
         sc_valid_q <= 1'b0;
         sc_fail_q <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         req_valid_q <= req_valid_d;
         sc_valid_q <= sc_valid_d;
         sc_fail_q <= sc_fail_d;
         perr_q <= perr_d;
      end
   end
   always_ff @(posedge clk) begin
      req_addr_q <= req_addr_d;
      req_be_q <= req_be_d;
      req_data_q <= req_data_d;
      req_sub_q <= req_sub_d;
      req_sc_q <= req_sc_d;
   end
   assign sq_pop = pop;
   assign mem_req_valid = req_valid_q;
   assign mem_req_addr = req_addr_q;
   assign mem_req_be = req_be_q;
   assign mem_req_data = req_data_q;
   assign mem_req_subunit = req_sub_q;
   assign mem_req_sc = req_sc_q;
   assign sc_result_valid = sc_valid_q;
   assign sc_result = {31'b0, sc_fail_q};
   assign protocol_error = perr_q;
   assign drain_empty = ~req_valid_q & (cnt_q == '0) & (state_q == IDLE);
endmodule

// File: tb/tb_store_drain_unit.sv
// tb_store_drain_unit: store-queue model feeding a request scoreboard, table-driven entries
// plus hand sequences for backpressure, limits, fences, SC handling and protocol errors.
module tb_store_drain_unit;
   localparam int MO = 4;
   localparam int SW = 2;
   logic clk = 1'b0;
   logic rst, sq_valid, sq_is_amo_sc, sq_pop, fence_req, mem_req_valid, mem_req_ready;
   logic [31:0] sq_addr, sq_data, mem_req_addr, mem_req_data, sc_result;
   logic [3:0] sq_be, mem_req_be;
   logic [SW-1:0] sq_subunit_id, mem_req_subunit;
   logic mem_req_sc, mem_ack, mem_sc_rsp_valid, mem_sc_rsp_fail;
   logic sc_result_valid, drain_empty, protocol_error;
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0] be;
      logic [31:0] data;
      logic [SW-1:0] sub;
      logic sc;
   } ent_t;
   typedef struct {
      ent_t e;
      int exp_issue;
   } vec_t;
   ent_t sq_m[$];
   ent_t exp_q[$];
   logic exp_sc[$];
   vec_t vec[4];
   int total = 0, bad = 0, hs = 0, scv = 0, run = 0, max_run = 0;
   int h0, c0;
   logic stable, nopop;
   logic [70:0] snap;

   store_drain_unit #(.MAX_OUTSTANDING(MO), .SUBUNIT_W(SW)) dut (
      .clk(clk), .rst(rst), .sq_valid(sq_valid), .sq_addr(sq_addr), .sq_be(sq_be),
      .sq_data(sq_data), .sq_subunit_id(sq_subunit_id), .sq_is_amo_sc(sq_is_amo_sc),
      .sq_pop(sq_pop), .fence_req(fence_req), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_be(mem_req_be),
      .mem_req_data(mem_req_data), .mem_req_subunit(mem_req_subunit), .mem_req_sc(mem_req_sc),
      .mem_ack(mem_ack), .mem_sc_rsp_valid(mem_sc_rsp_valid), .mem_sc_rsp_fail(mem_sc_rsp_fail),
      .sc_result_valid(sc_result_valid), .sc_result(sc_result), .drain_empty(drain_empty),
      .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", n, act, exp);
      end
   endtask

   function automatic ent_t mk(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                               input logic [SW-1:0] s, input logic c);
      mk = '{addr: a, be: b, data: d, sub: s, sc: c};
   endfunction

   task automatic refresh();
      sq_valid = sq_m.size() != 0;
      if (sq_m.size() != 0) {sq_addr, sq_be, sq_data, sq_subunit_id, sq_is_amo_sc} = sq_m[0];
   endtask

   task automatic push(input ent_t e);
      sq_m.push_back(e);
      refresh();
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ack(input int n);
      repeat (n) begin
         mem_ack = 1'b1;
         step(1);
         mem_ack = 1'b0;
         step(2);
      end
   endtask

   // store-queue model: consumes the head on sq_pop and predicts which entries reach memory
   always @(posedge clk) begin
      if (sq_pop) begin
         if (sq_m.size() == 0) chk("pop_empty_sq", 1, 0);
         else begin
            ent_t e;
            e = sq_m.pop_front();
            if (e.be != 4'b0 || e.sc) exp_q.push_back(e);
         end
      end
      #1 refresh();
   end

   always @(negedge clk) begin
      run = mem_req_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (mem_req_valid && mem_req_ready) begin
         hs++;
         if (exp_q.size() == 0) chk("req_unexpected", 1, 0);
         else chk("req_payload", {mem_req_addr, mem_req_be, mem_req_data, mem_req_subunit, mem_req_sc},
                  exp_q.pop_front());
      end
      if (sc_result_valid) begin
         scv++;
         if (exp_sc.size() == 0) chk("sc_unexpected", 1, 0);
         else chk("sc_result", sc_result, {31'b0, exp_sc.pop_front()});
      end
   end

   initial begin
      rst = 1'b1;
      {sq_valid, sq_addr, sq_be, sq_data, sq_subunit_id, sq_is_amo_sc} = '0;
      {fence_req, mem_ack, mem_sc_rsp_valid, mem_sc_rsp_fail} = '0;
      mem_req_ready = 1'b1;
      vec[0] = '{e: mk(32'h100, 4'hF, 32'hA0A0_0001, 2'd1, 1'b0), exp_issue: 1};
      vec[1] = '{e: mk(32'h104, 4'h0, 32'hDEAD_BEEF, 2'd2, 1'b0), exp_issue: 0};
      vec[2] = '{e: mk(32'h108, 4'h3, 32'h0000_5555, 2'd3, 1'b0), exp_issue: 1};
      vec[3] = '{e: mk(32'h10C, 4'h8, 32'h7700_0000, 2'd0, 1'b0), exp_issue: 1};
      step(2);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_sq_pop", sq_pop, 0);
      chk("rst_sc_valid", {sc_result_valid, sc_result}, 0);
      chk("rst_perr", protocol_error, 0);
      chk("rst_drain_empty", drain_empty, 1);
      rst = 1'b0;
      step(1);
      for (int i = 0; i < 4; i++) begin
         h0 = hs;
         push(vec[i].e);
         step(4);
         chk($sformatf("tbl_issue_%0d", i), hs - h0, vec[i].exp_issue);
         chk($sformatf("tbl_popped_%0d", i), sq_m.size(), 0);
      end
      chk("tbl_not_empty", drain_empty, 0);
      ack(2);
      chk("tbl_partial_drain", drain_empty, 0);
      ack(1);
      chk("tbl_drained", drain_empty, 1);
      // six stores against a limit of four with no acks
      h0 = hs;
      max_run = 0;
      for (int i = 0; i < 6; i++) push(mk(32'h200 + 32'(i * 4), 4'hF, 32'h1111_0000 + 32'(i), 2'(i), 1'b0));
      step(10);
      chk("limit_accepted", hs - h0, MO);
      chk("limit_back_to_back", max_run, MO);
      chk("limit_left_in_sq", sq_m.size(), 2);
      c0 = hs;
      ack(1);
      chk("limit_fifth_after_ack", hs - c0, 1);
      ack(5);
      chk("limit_all_issued", hs - h0, 6);
      chk("limit_drained", drain_empty, 1);
      // backpressure: payload frozen and no pops while ready is low
      mem_req_ready = 1'b0;
      push(mk(32'h300, 4'h5, 32'hCAFE_0001, 2'd2, 1'b0));
      push(mk(32'h304, 4'hA, 32'hCAFE_0002, 2'd1, 1'b0));
      step(2);
      snap = {mem_req_addr, mem_req_be, mem_req_data, mem_req_subunit, mem_req_sc};
      stable = 1'b1;
      nopop = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (!mem_req_valid || {mem_req_addr, mem_req_be, mem_req_data, mem_req_subunit, mem_req_sc} !== snap)
            stable = 1'b0;
         if (sq_pop) nopop = 1'b0;
         step(1);
      end
      chk("stall_stable", stable, 1);
      chk("stall_no_pop", nopop, 1);
      h0 = hs;
      mem_req_ready = 1'b1;
      step(4);
      chk("stall_release", hs - h0, 2);
      ack(2);
      // fence holds back new pops
      fence_req = 1'b1;
      push(mk(32'h400, 4'hF, 32'h0F0F_0F0F, 2'd3, 1'b0));
      step(3);
      chk("fence_no_pop", sq_m.size(), 1);
      chk("fence_drain_empty", drain_empty, 1);
      fence_req = 1'b0;
      step(3);
      chk("fence_release", sq_m.size(), 0);
      ack(1);
      // failing SC followed by a plain store
      push(mk(32'h1000, 4'hF, 32'h0000_0001, 2'd1, 1'b1));
      push(mk(32'h1004, 4'hF, 32'h0000_0002, 2'd1, 1'b0));
      step(1);
      step(4);
      chk("sc_blocks_store", sq_m.size(), 1);
      chk("sc_wait_not_empty", drain_empty, 0);
      c0 = scv;
      mem_sc_rsp_valid = 1'b1;
      mem_sc_rsp_fail = 1'b1;
      exp_sc.push_back(1'b1);
      step(1);
      mem_sc_rsp_valid = 1'b0;
      mem_sc_rsp_fail = 1'b0;
      step(3);
      chk("sc_fail_one_pulse", scv - c0, 1);
      chk("sc_store_after", sq_m.size(), 0);
      ack(1);
      // successful SC
      push(mk(32'h1008, 4'hF, 32'h0000_0003, 2'd0, 1'b1));
      step(3);
      c0 = scv;
      mem_sc_rsp_valid = 1'b1;
      exp_sc.push_back(1'b0);
      step(1);
      mem_sc_rsp_valid = 1'b0;
      step(2);
      chk("sc_ok_one_pulse", scv - c0, 1);
      chk("sc_ok_drained", drain_empty, 1);
      chk("no_perr_yet", protocol_error, 0);
      // stray ack with nothing outstanding
      mem_ack = 1'b1;
      step(1);
      mem_ack = 1'b0;
      step(3);
      chk("perr_stray_ack", protocol_error, 1);
      chk("perr_cnt_stays_zero", drain_empty, 1);
      // reset while waiting on an SC
      push(mk(32'h2000, 4'hF, 32'h0000_0004, 2'd2, 1'b1));
      step(3);
      chk("sc_wait_busy", drain_empty, 0);
      c0 = scv;
      rst = 1'b1;
      step(1);
      chk("rst_mid_drain_empty", drain_empty, 1);
      chk("rst_mid_perr", protocol_error, 0);
      rst = 1'b0;
      step(3);
      chk("rst_no_sc_result", scv - c0, 0);
      mem_sc_rsp_valid = 1'b1;
      step(1);
      mem_sc_rsp_valid = 1'b0;
      step(2);
      chk("perr_rsp_in_idle", protocol_error, 1);
      chk("rsp_in_idle_ignored", scv - c0, 0);
      chk("scoreboard_empty", exp_q.size() + exp_sc.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
